// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: FSM states, BCD digit
// type, digit limits and a single-digit BCD increment helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t MIN_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    // Returns {carry, next_digit}; the digit wraps to 0 and carries at its limit.
    function automatic logic [4:0] bcd_step(input bcd_t digit, input bcd_t limit);
        if (digit == limit) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, digit + 4'd1};
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchroniser chain plus history flop; emits a one-cycle pulse on each
// rising edge of an asynchronous level input.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   history;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: chain and history reset to 1 so a level already high at reset release is not seen as an edge.
            sync    <= '1;
            history <= 1'b1;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], level};
            history <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~history;

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch driven by a synchronised 1 Hz data input, with
// start/stop and clear buttons; all logic runs on clk.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slow_clk,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       sec_pulse,
    output logic       rollover
);

    logic   tick_rise;
    logic   ss_rise;
    logic   clear_rise;
    state_t state;
    state_t next_state;
    logic   count_en;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick  (.clk(clk), .rst(rst), .level(slow_clk),   .rise(tick_rise));
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss    (.clk(clk), .rst(rst), .level(start_stop), .rise(ss_rise));
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (.clk(clk), .rst(rst), .level(clear),      .rise(clear_rise));

    bcd_t next_so, next_st, next_mo, next_mt;
    logic carry_so, carry_st, carry_mo, wrap;

    // Ripple increment; when every digit is at its limit all four become 0 and wrap is set.
    always_comb begin
        {carry_so, next_so} = bcd_step(sec_ones, DIGIT_MAX);
        {carry_st, next_st} = carry_so ? bcd_step(sec_tens, SEC_TENS_MAX) : {1'b0, sec_tens};
        {carry_mo, next_mo} = carry_st ? bcd_step(min_ones, DIGIT_MAX)    : {1'b0, min_ones};
        {wrap,     next_mt} = carry_mo ? bcd_step(min_tens, MIN_TENS_MAX) : {1'b0, min_tens};
    end

    always_comb begin
        next_state = state;
        if (clear_rise) begin
            next_state = IDLE;
        end else if (ss_rise) begin
            next_state = (state == RUN) ? PAUSE : RUN;
        end
    end

    // A tick counts only against the current state, so a press in the same cycle
    // still lets RUN increment and keeps IDLE/PAUSE from incrementing.
    assign count_en = tick_rise && (state == RUN) && !clear_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            running   <= 1'b0;
            sec_pulse <= 1'b0;
            rollover  <= 1'b0;
            sec_ones  <= '0;
            sec_tens  <= '0;
            min_ones  <= '0;
            min_tens  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update reading pre-edge values.
            state     <= next_state;
            running   <= (next_state == RUN);
            sec_pulse <= count_en;
            rollover  <= count_en & wrap;
            if (clear_rise) begin
                sec_ones <= '0;
                sec_tens <= '0;
                min_ones <= '0;
                min_tens <= '0;
            end else if (count_en) begin
                sec_ones <= next_so;
                sec_tens <= next_st;
                min_ones <= next_mo;
                min_tens <= next_mt;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: table of press/tick scenarios plus
// hand-written latency, carry, wrap and simultaneous-event sequences.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       slow_clk = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, sec_pulse, rollover;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int roll_cnt = 0;

    stopwatch_core #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .slow_clk(slow_clk), .start_stop(start_stop), .clear(clear),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .sec_pulse(sec_pulse), .rollover(rollover)
    );

    always #5 clk = ~clk;

    // Count strobe-high cycles mid-cycle, well before the negedge sampling point.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            if (sec_pulse) pulse_cnt++;
            if (rollover)  roll_cnt++;
        end
    end

    typedef struct {
        string       name;
        bit          ss;
        bit          clr;
        bit          tick_with;
        int          ticks;
        logic [15:0] exp_time;
        bit          exp_run;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] now_time();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Raise the selected inputs together, hold, drop, then idle; updates settle within the high phase.
    task automatic pulse_inputs(input bit s, input bit ss, input bit c, input int half);
        @(negedge clk);
        slow_clk = s; start_stop = ss; clear = c;
        wait_neg(half);
        slow_clk = 1'b0; start_stop = 1'b0; clear = 1'b0;
        wait_neg(half);
    endtask

    task automatic ticks(input int n, input int half);
        for (int i = 0; i < n; i++) pulse_inputs(1'b1, 1'b0, 1'b0, half);
    endtask

    initial begin
        int base;
        vecs[0] = '{"run_two_more",  1'b0, 1'b0, 1'b0,  2, 16'h0003, 1'b1,  2};
        vecs[1] = '{"pause_hold",    1'b1, 1'b0, 1'b0,  5, 16'h0003, 1'b0,  0};
        vecs[2] = '{"resume_one",    1'b1, 1'b0, 1'b0,  1, 16'h0004, 1'b1,  1};
        vecs[3] = '{"tick_ss_run",   1'b1, 1'b0, 1'b1,  0, 16'h0005, 1'b0,  1};
        vecs[4] = '{"tick_ss_pause", 1'b1, 1'b0, 1'b1,  0, 16'h0005, 1'b1,  0};
        vecs[5] = '{"clear_idle",    1'b0, 1'b1, 1'b0,  0, 16'h0000, 1'b0,  0};
        vecs[6] = '{"tick_in_idle",  1'b0, 1'b0, 1'b0,  2, 16'h0000, 1'b0,  0};
        vecs[7] = '{"tick_ss_idle",  1'b1, 1'b0, 1'b1,  0, 16'h0000, 1'b1,  0};
        vecs[8] = '{"run_to_0059",   1'b0, 1'b0, 1'b0, 59, 16'h0059, 1'b1, 59};
        vecs[9] = '{"carry_0100",    1'b0, 1'b0, 1'b0,  1, 16'h0100, 1'b1,  1};

        // Reset with slow_clk and start_stop held high: no edge may leak through.
        rst = 1'b1; slow_clk = 1'b1; start_stop = 1'b1;
        wait_neg(3);
        rst = 1'b0;
        wait_neg(10);
        check("reset_digits",  now_time(), 16'h0000);
        check("reset_running", running, 1'b0);
        check("reset_pulses",  pulse_cnt, 0);
        slow_clk = 1'b0; start_stop = 1'b0;
        wait_neg(6);
        check("reset_release_idle", {running, now_time()}, 17'h0_0000);

        // Press latency: running rises at the second edge after the first sampling edge.
        start_stop = 1'b1;
        wait_neg(1); check("press_lat_e0", running, 1'b0);
        wait_neg(1); check("press_lat_e1", running, 1'b0);
        wait_neg(1); check("press_lat_e2", running, 1'b1);
        wait_neg(7); start_stop = 1'b0; wait_neg(10);

        // Tick latency and one-cycle sec_pulse width.
        slow_clk = 1'b1;
        wait_neg(2); check("tick_lat_e1", {sec_pulse, now_time()}, 17'h0_0000);
        wait_neg(1); check("tick_lat_e2", {sec_pulse, now_time()}, 17'h1_0001);
        wait_neg(1); check("tick_pulse_width", sec_pulse, 1'b0);
        wait_neg(6); slow_clk = 1'b0; wait_neg(10);

        foreach (vecs[i]) begin
            base = pulse_cnt;
            if (vecs[i].ss || vecs[i].clr || vecs[i].tick_with)
                pulse_inputs(vecs[i].tick_with, vecs[i].ss, vecs[i].clr, 10);
            ticks(vecs[i].ticks, 10);
            check({vecs[i].name, "_time"},    now_time(), vecs[i].exp_time);
            check({vecs[i].name, "_running"}, running, vecs[i].exp_run);
            check({vecs[i].name, "_pulses"},  pulse_cnt - base, vecs[i].exp_pulses);
        end

        // Minute-tens carry, then up to the wrap.
        ticks(539, 4);
        check("at_0959", now_time(), 16'h0959);
        ticks(1, 4);
        check("carry_1000", now_time(), 16'h1000);
        check("no_rollover_yet", roll_cnt, 0);
        ticks(2999, 4);
        check("at_5959", now_time(), 16'h5959);
        ticks(1, 4);
        check("wrap_time", now_time(), 16'h0000);
        check("wrap_rollover_once", roll_cnt, 1);
        check("wrap_running", running, 1'b1);

        // clear and tick arriving together at 12:34.
        ticks(754, 4);
        check("at_1234", now_time(), 16'h1234);
        base = pulse_cnt;
        pulse_inputs(1'b1, 1'b0, 1'b1, 6);
        check("clr_tick_time", now_time(), 16'h0000);
        check("clr_tick_idle", running, 1'b0);
        check("clr_tick_no_pulse", pulse_cnt - base, 0);

        // clear and start_stop together from RUN: clear wins.
        pulse_inputs(1'b0, 1'b1, 1'b0, 6);
        ticks(2, 4);
        check("pre_clr_ss_run", {running, now_time()}, 17'h1_0002);
        pulse_inputs(1'b0, 1'b1, 1'b1, 6);
        check("clr_ss_idle", {running, now_time()}, 17'h0_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping stage fed directly by the clock divider. It takes the divider's 1 Hz toggling output as a plain data input, synchronises it into `clk`, and converts each rising edge into a one-second count. It keeps an MM:SS BCD count with start/stop/clear control, and its outputs feed the display stage. No logic is clocked by the slow signal.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth per asynchronous input; legal values ≥2.

Ports:
- `clk`  in  1  system clock, 50 MHz board clock.
- `rst`  in  1  reset; synchronous, active-high.
- `slow_clk`  in  1  1 Hz square wave from the divider; treated as asynchronous data.
- `start_stop`  in  1  debounced button level; each rising edge toggles run/pause.
- `clear`  in  1  debounced button level; each rising edge zeroes the count and goes idle.
- `sec_ones`  out  4  BCD seconds units, 0–9.
- `sec_tens`  out  4  BCD seconds tens, 0–5.
- `min_ones`  out  4  BCD minutes units, 0–9.
- `min_tens`  out  4  BCD minutes tens, 0–5.
- `running`  out  1  high while in RUN.
- `sec_pulse`  out  1  one-cycle strobe, high in the cycle the count changes.
- `rollover`  out  1  one-cycle strobe, high in the cycle the count wraps from 59:59 to 00:00.

## Operation
- Input conditioning: each of `slow_clk`, `start_stop` and `clear` goes through `SYNC_STAGES` flops, then one history flop.
  - Edge pulse = sync_out & ~history, combinational.
  - All synchroniser and history flops reset to 1, so an input held high through reset produces no edge.
- State machine: IDLE, RUN, PAUSE. Reset state is IDLE.
  - `start_stop` edge: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
  - `clear` edge from any state: go to IDLE and zero all digits.
  - `clear` edge and `start_stop` edge in the same cycle: clear wins, result is IDLE.
- Counting: only a `slow_clk` edge while in RUN increments the count. Edges in IDLE or PAUSE are discarded, not queued.
- Increment is a BCD ripple:
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into min_ones.
  - min_ones 9→0 carries into min_tens.
  - min_tens 5→0 is the wrap: all digits become 0, `rollover`=1, state stays RUN.
- Simultaneous events:
  - tick + clear: clear wins; digits become 0; no `sec_pulse`.
  - tick + `start_stop` edge in RUN: the increment is applied and the state moves to PAUSE.
  - tick + `start_stop` edge in PAUSE or IDLE: no increment; the state moves to RUN.
- `running` is a registered copy of (state == RUN).
- Reset values: all digits 0, `running`=0, `sec_pulse`=0, `rollover`=0, state IDLE.
- Reset asserted mid-count takes effect on the next `clk` edge regardless of any pending edges.

## Timing
- The input path is registered; state and digit updates land on the clk edge at which the edge pulse is high.
- `slow_clk` latency, `SYNC_STAGES`=2, first sampled high at edge E0:
  - pulse is high during the cycle after E1;
  - digits, `sec_pulse` and `rollover` update at E2.
- Button latency is identical: the state changes at E2. `running` follows the state change at the same edge.
- `sec_pulse` and `rollover` are exactly one `clk` cycle wide. With the divider's 25,000,000-cycle half-period, increments are 50,000,000 cycles apart.
- Minimum input high/low time is `SYNC_STAGES`+1 clk cycles; shorter pulses may be missed.

## Structure
- Package `stopwatch_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE);
  - the 4-bit `bcd_t` type;
  - constants SEC_TENS_MAX=5, MIN_TENS_MAX=5, DIGIT_MAX=9.
- One sub-module, `edge_sync` (parameter `SYNC_STAGES`): synchroniser plus history flop plus rising-edge pulse. It is instantiated three times.
- Counter and FSM stay flat in `stopwatch_core`.

## Test plan
- **Reset with inputs held high:**
  - Stimulus: `rst` for 3 cycles with `slow_clk`=1 and `start_stop`=1, then release.
  - Required: all digits 0, `running`=0, no `sec_pulse` for 10 cycles.
- **Basic run:**
  - Stimulus: `start_stop` edge, then 3 `slow_clk` rising edges (shortened period, 20 cycles).
  - Required: `running`=1 two edges after the press; exactly 3 `sec_pulse`; count 00:03.
- **Pause:**
  - Stimulus: from 00:03, `start_stop` edge, then 5 `slow_clk` edges, then `start_stop` edge, then 1 `slow_clk` edge.
  - Required: count stays 00:03 while paused, then 00:04.
- **Carries:**
  - Stimulus: count to 00:59, then one tick; count to 09:59, then one tick.
  - Required: 01:00 and 10:00 respectively; `rollover` stays 0.
- **Wrap:**
  - Stimulus: count to 59:59, then one tick.
  - Required: 00:00, `rollover`=1 for one cycle, `running` stays 1.
- **Simultaneous events:**
  - Stimulus: `clear` and a `slow_clk` edge land in the same cycle at 12:34.
  - Required: 00:00, state IDLE, no `sec_pulse`.
  - Stimulus: `clear` and `start_stop` edges together.
  - Required: state IDLE.
